ctrl_step_seq: RTL and testbench
================================

Name: ctrl_step_seq

Overview:
Parametrised control-step timing generator for the multi-cycle CPU datapath. It steps the processor through T0..T(N-1), holds each step for HOLD clocks and drives a strobe window inside each step, so control signals assert after a lead guard and drop before a trailing guard. It supports early sequence end (short instructions), memory stall, synchronous clear, back-to-back sequences and a sequence counter. It sits between the clock and ctrl_unit and replaces the fixed T-state stepping used in datapath benches.

Parameters:
NUM_STEPS, 8, number of control steps per sequence (>=2)
STEP_W, 3, width of step_idx (2**STEP_W >= NUM_STEPS)
HOLD, 4, clocks per step (>= LEAD+TRAIL+1)
LEAD, 1, clocks at step start with window low
TRAIL, 1, clocks at step end with window low
COUNT_W, 16, width of seq_count
Illegal combinations are an elaboration error.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  start request / continue with the next sequence
end_seq  in  1  from ctrl_unit: finish the sequence after the current step
stall  in  1  freeze step timing (memory wait)
clr  in  1  synchronous abort to IDLE
step_idx  out  STEP_W  current step number
step_onehot  out  NUM_STEPS  one-hot step, all zero when idle
window  out  1  control-strobe valid
busy  out  1  sequence in progress
done  out  1  one-cycle pulse: sequence completed
seq_count  out  COUNT_W  completed sequences, wraps

Behaviour:
- Reset: one clock (clk); reset is asynchronous, active-low. All outputs are 0 and the FSM is in IDLE.
- All outputs are registered.
- FSM states are IDLE, STEP, and PAUSE (PAUSE exists only with the optional feature).
- IDLE: when run=1 is sampled, the next cycle enters STEP with step_idx=0 and cnt=0, and busy=1.
- STEP: cnt counts 0..HOLD-1 and holds while stall=1. When cnt==HOLD-1 and stall=0, the step ends and step_idx increments.
- window = busy & (cnt>=LEAD) & (cnt<HOLD-TRAIL). It reflects the frozen cnt during stall.
- end_seq is latched (end_pend) on any STEP cycle and cleared when the sequence ends.
- Sequence end occurs at the final cycle of a step when end_pend=1, end_seq=1, or step_idx==NUM_STEPS-1.
  - The next cycle pulses done and increments seq_count (wrapping).
  - If run=1 at the final cycle, the next cycle restarts step_idx=0, cnt=0 with no idle gap. Otherwise the FSM goes to IDLE and busy=0.
- clr (priority over everything but reset): the next cycle is IDLE, all outputs except seq_count are 0, there is no done pulse, and end_pend is cleared.
- stall and end_seq in the same cycle: end_seq is latched and the step still waits for stall to drop.
- run is ignored while busy except at the sequence-end decision.
- step_onehot = busy ? (1<<step_idx) : 0.
- Asynchronous reset mid-step forces all outputs to zero immediately.

Optional Feature:
CTRL_STEP_SEQ_SINGLE_STEP_EN
- Defined: adds inputs single_mode and step_go.
  - With single_mode=1, each step end goes to PAUSE instead of advancing. In PAUSE, busy=1, window=0 and step_idx holds the completed step.
  - A step_go pulse advances to the next step with cnt=0, or performs the sequence-end handling if that step was final.
  - clr and reset exit PAUSE.
- Not defined: no extra ports, no PAUSE state, and the sequencer free-runs.

Test Plan:
- Reset and run: hold reset low, then release; pulse run at cycle 0. Outputs are 0 during reset. busy=1 from cycle 1. step_idx steps 0..7, 4 cycles each. window is high on cnt 1,2 of each step. done pulses at cycle 33, then busy=0 and seq_count=1.
- Back-to-back: run held high. At cycle 33 step_idx=0 with busy still 1, done pulses, and seq_count=1; after the second sequence seq_count=2.
- Early end: pulse end_seq during step 3 cnt=1. Step 3 completes, done pulses the next cycle, step 4 never appears, and step_onehot=8'h00 afterwards.
- Stall: assert stall for 5 cycles starting at step 2 cnt=1. Step 2 lasts 9 cycles, window stays high 7 consecutive cycles, and later steps keep 4 cycles each.
- clr/reset: assert clr at step 5. The next cycle has busy=0, step_onehot=0, no done, and seq_count unchanged. Separately, drop reset mid-step 6: outputs are 0 immediately.
- Macro defined: single_mode=1 gives PAUSE after step 0 with window=0 for 10 cycles; step_go then starts step 1. Macro undefined: the same stimulus free-runs.

Source files
------------

// File: rtl/ctrl_step_seq.sv
// Control-step timing generator: steps T0..T(NUM_STEPS-1), HOLD clocks each, with a guarded strobe window.
// Optional single-step mode (step_go advances from PAUSE) under `define CTRL_STEP_SEQ_SINGLE_STEP_EN.
`timescale 1ns/1ps
module ctrl_step_seq #(
  parameter int unsigned NUM_STEPS = 8,
  parameter int unsigned STEP_W    = 3,
  parameter int unsigned HOLD      = 4,
  parameter int unsigned LEAD      = 1,
  parameter int unsigned TRAIL     = 1,
  parameter int unsigned COUNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 end_seq,
  input  logic                 stall,
  input  logic                 clr,
`ifdef CTRL_STEP_SEQ_SINGLE_STEP_EN
  input  logic                 single_mode,
  input  logic                 step_go,
`endif
  output logic [STEP_W-1:0]    step_idx,
  output logic [NUM_STEPS-1:0] step_onehot,
  output logic                 window,
  output logic                 busy,
  output logic                 done,
  output logic [COUNT_W-1:0]   seq_count
);

  localparam int unsigned CNT_W = (HOLD > 2) ? $clog2(HOLD) : 2;

  generate
    if (NUM_STEPS < 2 || STEP_W < 1 || (2 ** STEP_W) < NUM_STEPS ||
        HOLD < LEAD + TRAIL + 1 || COUNT_W < 1) begin : g_bad_params
      $error("ctrl_step_seq: illegal parameter combination");
    end
  endgenerate

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STEP  = 2'd1;
`ifdef CTRL_STEP_SEQ_SINGLE_STEP_EN
  localparam logic [1:0] S_PAUSE = 2'd2;
`endif

  logic [1:0]           state_q, state_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 end_pend_q, end_pend_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 window_q, window_d;
  logic [NUM_STEPS-1:0] onehot_q, onehot_d;
  logic [COUNT_W-1:0]   seq_count_q, seq_count_d;
  logic                 advance;
  logic                 seq_end;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    end_pend_d  = end_pend_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    seq_count_d = seq_count_q;
    advance     = 1'b0;
    seq_end     = end_pend_q | end_seq | (step_q == STEP_W'(NUM_STEPS - 1));

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d    = S_STEP;
          step_d     = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          end_pend_d = 1'b0;
        end
      end
      S_STEP: begin
        if (end_seq) end_pend_d = 1'b1;
        if (!stall) begin
          if (cnt_q != CNT_W'(HOLD - 1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
`ifdef CTRL_STEP_SEQ_SINGLE_STEP_EN
            if (single_mode) state_d = S_PAUSE;
            else             advance = 1'b1;
`else
            advance = 1'b1;
`endif
          end
        end
      end
`ifdef CTRL_STEP_SEQ_SINGLE_STEP_EN
      S_PAUSE: begin
        if (end_seq) end_pend_d = 1'b1;
        if (step_go) advance = 1'b1;
      end
`endif
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Step boundary: either move to the next step or close the sequence (restart if run is held).
    if (advance) begin
      cnt_d = '0;
      if (seq_end) begin
        done_d      = 1'b1;
        seq_count_d = seq_count_q + COUNT_W'(1);
        end_pend_d  = 1'b0;
        step_d      = '0;
        state_d     = run ? S_STEP : S_IDLE;
        busy_d      = run;
      end else begin
        step_d  = step_q + STEP_W'(1);
        state_d = S_STEP;
      end
    end

    if (clr) begin
      state_d     = S_IDLE;
      step_d      = '0;
      cnt_d       = '0;
      end_pend_d  = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      seq_count_d = seq_count_q;
    end

    window_d = busy_d && (state_d == S_STEP) &&
               (32'(cnt_d) >= LEAD) && (32'(cnt_d) < HOLD - TRAIL);
    onehot_d = busy_d ? (NUM_STEPS'(1) << step_d) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      cnt_q       <= '0;
      end_pend_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      window_q    <= 1'b0;
      onehot_q    <= '0;
      seq_count_q <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      end_pend_q  <= end_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      window_q    <= window_d;
      onehot_q    <= onehot_d;
      seq_count_q <= seq_count_d;
    end
  end

  assign step_idx    = step_q;
  assign step_onehot = onehot_q;
  assign window      = window_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign seq_count   = seq_count_q;

endmodule

// File: tb/tb_ctrl_step_seq.sv
// Scoreboard bench for ctrl_step_seq (NUM_STEPS=8, HOLD=4, LEAD=TRAIL=1): stimulus queues per-cycle expectations.
`timescale 1ns/1ps
module tb_ctrl_step_seq;
  logic        clk = 1'b0;
  logic        reset, run, end_seq, stall, clr;
`ifdef CTRL_STEP_SEQ_SINGLE_STEP_EN
  logic        single_mode, step_go;
`endif
  logic [2:0]  step_idx;
  logic [7:0]  step_onehot;
  logic        window, busy, done;
  logic [15:0] seq_count;

  typedef struct {
    string       nm;
    logic [2:0]  st;
    logic        bz;
    logic        wn;
    logic        dn;
    logic [15:0] sc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ecount   = 0;

  always #5 clk = ~clk;

  ctrl_step_seq #(
    .NUM_STEPS(8), .STEP_W(3), .HOLD(4), .LEAD(1), .TRAIL(1), .COUNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .end_seq(end_seq), .stall(stall), .clr(clr),
`ifdef CTRL_STEP_SEQ_SINGLE_STEP_EN
    .single_mode(single_mode), .step_go(step_go),
`endif
    .step_idx(step_idx), .step_onehot(step_onehot), .window(window),
    .busy(busy), .done(done), .seq_count(seq_count)
  );

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h required %0h (t=%0t)", nm, f, act, req, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk(mon_e.nm, "busy",      32'(busy),        32'(mon_e.bz));
      chk(mon_e.nm, "step_idx",  32'(step_idx),    32'(mon_e.st));
      chk(mon_e.nm, "onehot",    32'(step_onehot), mon_e.bz ? (32'd1 << mon_e.st) : 32'd0);
      chk(mon_e.nm, "window",    32'(window),      32'(mon_e.wn));
      chk(mon_e.nm, "done",      32'(done),        32'(mon_e.dn));
      chk(mon_e.nm, "seq_count", 32'(seq_count),   32'(mon_e.sc));
    end
  end

  task automatic push(input string nm, input int st, input logic bz, input logic wn, input logic dn);
    exp_t e;
    e.nm = nm; e.st = 3'(st); e.bz = bz; e.wn = wn; e.dn = dn; e.sc = 16'(ecount);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input string nm, input logic r, input logic e, input logic s, input logic c,
                     input int st, input logic bz, input logic wn, input logic dn);
    @(posedge clk); #1;
    run = r; end_seq = e; stall = s; clr = c;
    push(nm, st, bz, wn, dn);
  endtask

  // k = cycle number within a free-running sequence (1..32): step (k-1)/4, cnt (k-1)%4.
  task automatic kc(input string nm, input int k, input logic r, input logic e, input logic s,
                    input logic c, input logic dn);
    cyc(nm, r, e, s, c, (k - 1) / 4, 1'b1, ((k - 1) % 4 == 1) || ((k - 1) % 4 == 2), dn);
  endtask

  task automatic play(input string nm, input int k0, input int k1, input logic r, input logic first_dn);
    for (int k = k0; k <= k1; k++) kc(nm, k, r, 1'b0, 1'b0, 1'b0, first_dn && (k == k0));
  endtask

  task automatic idle(input string nm, input logic r);
    cyc(nm, r, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fin_idle(input string nm);
    cyc(nm, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; end_seq = 1'b0; stall = 1'b0; clr = 1'b0;
`ifdef CTRL_STEP_SEQ_SINGLE_STEP_EN
    single_mode = 1'b0; step_go = 1'b0;
`endif
    // Reset, then single sequence
    repeat (3) idle("in_reset", 1'b0);
    #2 reset = 1'b1;
    idle("run_pulse", 1'b1);
    play("seq1", 1, 32, 1'b0, 1'b0);
    ecount++;
    fin_idle("seq1_done");
    idle("seq1_idle", 1'b0);

    // Back-to-back with run held
    idle("b2b_start", 1'b1);
    play("b2b_a", 1, 32, 1'b1, 1'b0);
    ecount++;
    play("b2b_b", 1, 32, 1'b0, 1'b1);
    ecount++;
    fin_idle("b2b_done");
    idle("b2b_idle", 1'b0);

    // Early end: end_seq at step 3 cnt 1
    idle("early_start", 1'b1);
    play("early", 1, 13, 1'b0, 1'b0);
    kc("early_es", 14, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    play("early_tail", 15, 16, 1'b0, 1'b0);
    ecount++;
    fin_idle("early_done");
    repeat (3) idle("early_idle", 1'b0);

    // Stall 5 cycles at step 2 cnt 1
    idle("stall_start", 1'b1);
    play("stall_pre", 1, 9, 1'b0, 1'b0);
    repeat (5) cyc("stall_hold", 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0);
    play("stall_post", 10, 32, 1'b0, 1'b0);
    ecount++;
    fin_idle("stall_done");
    idle("stall_idle", 1'b0);

    // clr at step 5
    idle("clr_start", 1'b1);
    play("clr_pre", 1, 20, 1'b0, 1'b0);
    kc("clr_at5", 21, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) idle("clr_after", 1'b0);

    // clr discards a pending end_seq: the next sequence runs all 8 steps
    idle("clr2_start", 1'b1);
    play("clr2_pre", 1, 9, 1'b0, 1'b0);
    kc("clr2_es", 10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    kc("clr2_clr", 11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("clr2_after", 1'b1);
    play("clr2_full", 1, 32, 1'b0, 1'b0);
    ecount++;
    fin_idle("clr2_done");
    idle("clr2_idle", 1'b0);

    // Asynchronous reset during step 6
    idle("arst_start", 1'b1);
    play("arst_pre", 1, 25, 1'b0, 1'b0);
    @(posedge clk); #1;
    run = 1'b0;
    ecount = 0;
    push("arst_now", 0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    idle("arst_hold", 1'b0);
    #2 reset = 1'b1;
    idle("arst_rel", 1'b0);

`ifdef CTRL_STEP_SEQ_SINGLE_STEP_EN
    // Single-step: PAUSE after step 0 for 10 cycles, step_go starts step 1
    single_mode = 1'b1;
    idle("ss_start", 1'b1);
    play("ss_step0", 1, 4, 1'b0, 1'b0);
    repeat (10) cyc("ss_pause", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    step_go = 1'b1;
    kc("ss_go", 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step_go = 1'b0;
    single_mode = 1'b0;
    play("ss_rest", 6, 32, 1'b0, 1'b0);
`else
    // Without single-step support the same run free-runs
    idle("ss_start", 1'b1);
    play("ss_free", 1, 32, 1'b0, 1'b0);
`endif
    ecount++;
    fin_idle("ss_done");
    idle("ss_idle", 1'b0);

    repeat (2) @(posedge clk);
    chk("scoreboard", "drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
